seq_divider: RTL

- Iterative unsigned restoring divider, one quotient bit per clock.
- Produces the 64-bit quotient driven onto the ALU result mux `div` input (mux select 3).
- Start/done handshake lets the execute control hold the mux select until the result is valid.
- Remainder and divide-by-zero flag are exported for status/flags logic.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/div_step.sv | 28 ++
 rtl/seq_divider.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: data width, divider FSM states and result-mux selects.
// Imported by the divider datapath, its step unit and the execute-stage mux.
package alu_pkg;

   localparam int DATA_W = 64;

   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Result-mux selects; the divider quotient feeds SEL_DIV.
   typedef enum logic [1:0] {
      SEL_ADD = 2'd0,
      SEL_SUB = 2'd1,
      SEL_MUL = 2'd2,
      SEL_DIV = 2'd3
   } alu_sel_t;

   // Iteration counter width: must reach w without wrapping.
   function automatic int div_cnt_w(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract D.
// Ports: r_i/q_i/d_i current partial remainder, quotient, divisor; r_o/q_o next.
module div_step
   import alu_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic [W:0]   r_i,
   input  logic [W-1:0] q_i,
   input  logic [W-1:0] d_i,
   output logic [W:0]   r_o,
   output logic [W-1:0] q_o
);

   logic [W+1:0] shl;
   logic [W+1:0] trial;
   logic         neg;

   // R < D always holds between steps, so the shifted value fits in W+1
   // bits; the extra top bit just keeps the subtraction sign clean.
   assign shl   = {r_i, q_i[W-1]};
   assign trial = shl - {2'b00, d_i};
   assign neg   = trial[W+1];

   assign r_o = neg ? shl[W:0] : trial[W:0];
   assign q_o = {q_i[W-2:0], ~neg};

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports: clk, reset (sync, active-high); start/dividend/divisor request;
//        busy, done pulse, quotient, remainder, div_by_zero results.
module seq_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = div_cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   step_r;
   logic [WIDTH-1:0] step_q;

   div_step #(
      .W (WIDTH)
   ) u_step (
      .r_i (r_q),
      .q_i (q_q),
      .d_i (d_q),
      .r_o (step_r),
      .q_o (step_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         RUN: begin
            r_d   = step_r;
            q_d   = step_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               quot_d  = step_q;
               rem_d   = step_r[WIDTH-1:0];
               dbz_d   = 1'b0;
               state_d = DONE;
            end
         end
         IDLE, DONE: begin
            if (start) begin
               d_d   = divisor;
               q_d   = dividend;
               r_d   = '0;
               cnt_d = '0;
               // Zero divisor short-circuits straight to DONE.
               if (divisor == '0) begin
                  quot_d  = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule
